// File: rtl/alu_exec_mc.sv
// Multi-cycle EX-stage ALU with internal aluop/func decode and valid/ready on both sides.
// Define ALU_MULT_EN to build the iterative multu datapath with its HI/LO registers.
module alu_exec_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluop,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
    OP_MULTU, OP_MFHI, OP_MFLO, OP_ILL
  } op_e;

  op_e              op;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] sc_result;
  logic             sc_err;

  assign accept = in_valid && in_ready;

  // NOTE: every signal driven from always_comb gets a default first, so no latch is inferred.
  always_comb begin
    op = OP_ILL;
    unique case (aluop)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (func)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b100110: op = OP_XOR;
          6'b100111: op = OP_NOR;
          6'b101010: op = OP_SLT;
`ifdef ALU_MULT_EN
          6'b011001: op = OP_MULTU;
          6'b010000: op = OP_MFHI;
          6'b010010: op = OP_MFLO;
`endif
          default:   op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

`ifdef ALU_MULT_EN
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e             state, state_next;
  logic [WIDTH-1:0]   hi, lo, mcand;
  logic [2*WIDTH-1:0] prod, prod_step;
  logic [WIDTH:0]     step_sum;
  logic [CNT_W-1:0]   cnt;
  logic               last_step;

  // One shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  assign step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_step = {step_sum, prod[WIDTH-1:1]};
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
  assign mul_start = accept && (op == OP_MULTU);
  assign mul_done  = (state == S_MUL) && last_step;
  assign mul_lo    = prod_step[WIDTH-1:0];

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (mul_start) state_next = S_MUL;
      S_MUL:  if (last_step) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      prod  <= '0;
      cnt   <= '0;
    end else if (mul_start) begin
      mcand <= a;
      prod  <= {{WIDTH{1'b0}}, b};
      cnt   <= '0;
    end else if (state == S_MUL) begin
      prod <= prod_step;
      cnt  <= cnt + CNT_W'(1);
      if (last_step) begin
        hi <= prod_step[2*WIDTH-1:WIDTH];
        lo <= prod_step[WIDTH-1:0];
      end
    end
  end
`else
  assign in_ready  = !out_valid || out_ready;
  assign mul_start = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_lo    = '0;
`endif

  always_comb begin
    sc_result = '0;
    sc_err    = 1'b0;
    unique case (op)
      OP_ADD: sc_result = a + b;
      OP_SUB: sc_result = a - b;
      OP_AND: sc_result = a & b;
      OP_OR:  sc_result = a | b;
      OP_XOR: sc_result = a ^ b;
      OP_NOR: sc_result = ~(a | b);
      OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_MULT_EN
      OP_MFHI: sc_result = hi;
      OP_MFLO: sc_result = lo;
`endif
      default: sc_err = 1'b1;
    endcase
  end

  // A new result may load in the same cycle the previous one is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_lo;
      zero      <= (mul_lo == '0);
      err       <= 1'b0;
    end else if (accept && !mul_start) begin
      out_valid <= 1'b1;
      result    <= sc_result;
      zero      <= (sc_result == '0);
      err       <= sc_err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_mc.sv
// Scoreboard bench for alu_exec_mc: the driver queues expected results, a monitor checks them.
// Multiply vectors are exercised only when ALU_MULT_EN is defined.
module tb_alu_exec_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   aluop;
  logic [5:0]   func;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         err;

  alu_exec_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .func      (func),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         err;
    int           avail;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] xa,
                      input logic [W-1:0] xb, input logic [W-1:0] er, input logic ee,
                      input int lat);
    bit acc = 1'b0;
    in_valid = 1'b1;
    aluop    = op;
    func     = fn;
    a        = xa;
    b        = xb;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        sb.push_back('{res: er, zero: (er == '0), err: ee, avail: cyc + 1 + lat});
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares every handshaken result and checks arrival cycle and hold stability.
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [W-1:0] prev_result = '0;
  logic         prev_zero = 1'b0;
  logic         prev_err = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (out_valid && sb.size() != 0 && (!prev_valid || prev_ready))
        check("arrival_cycle", 64'(cyc), 64'(sb[0].avail));
      if (out_valid && prev_valid && !prev_ready) begin
        check("hold_result", 64'(result), 64'(prev_result));
        check("hold_flags", {62'd0, zero, err}, {62'd0, prev_zero, prev_err});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(result), 64'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", 64'(result), 64'(e.res));
          check("zero", 64'(zero), 64'(e.zero));
          check("err", 64'(err), 64'(e.err));
        end
      end
      prev_valid  = out_valid;
      prev_ready  = out_ready;
      prev_result = result;
      prev_zero   = zero;
      prev_err    = err;
    end
  end

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    aluop     = 2'b00;
    func      = 6'd0;
    a         = 32'd1;
    b         = 32'd2;
    out_ready = 1'b1;

    // Reset with a request pending: nothing may be accepted.
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single-cycle decode and arithmetic, back to back.
    send(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 0);
    send(2'b10, 6'b100111, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    send(2'b10, 6'b101010, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 0);
    send(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 0);
    send(2'b01, 6'b000000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0);
    send(2'b10, 6'b100000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 0);
    send(2'b10, 6'b100010, 32'h0000_0010, 32'h0000_0003, 32'h0000_000D, 1'b0, 0);
    send(2'b10, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 0);
    send(2'b10, 6'b100101, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 0);
    send(2'b10, 6'b100110, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 0);

    // Illegal encodings: zero result, err flag, single-cycle latency.
    send(2'b11, 6'b100000, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 1'b1, 0);
    send(2'b10, 6'b000000, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 1'b1, 0);

`ifdef ALU_MULT_EN
    send(2'b10, 6'b011001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, W);
    @(negedge clk);
    check("mul_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    send(2'b10, 6'b010000, 32'h0, 32'h0, 32'h0000_0001, 1'b0, 0);
    send(2'b10, 6'b010010, 32'h0, 32'h0, 32'h0000_0000, 1'b0, 0);
    send(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, W);
    send(2'b10, 6'b010000, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b0, 0);
`else
    send(2'b10, 6'b011001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 0);
    send(2'b10, 6'b010000, 32'h0, 32'h0, 32'h0000_0000, 1'b1, 0);
`endif

    // Back-pressure: result held while out_ready is low, then a queued op follows with no bubble.
    idle(1);
    out_ready = 1'b0;
    send(2'b00, 6'b000000, 32'd5, 32'd7, 32'd12, 1'b0, 0);
    repeat (3) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_result", 64'(result), 64'd12);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(2'b01, 6'b000000, 32'd7, 32'd5, 32'd2, 1'b0, 0);
    idle(1);

    // Reset in the middle of a multiply aborts it and clears HI/LO.
`ifdef ALU_MULT_EN
    send(2'b10, 6'b011001, 32'd3, 32'd5, 32'd15, 1'b0, W);
    send(2'b10, 6'b010010, 32'h0, 32'h0, 32'd15, 1'b0, 0);
    send(2'b10, 6'b011001, 32'd7, 32'd9, 32'd63, 1'b0, W);
`else
    send(2'b00, 6'b000000, 32'd3, 32'd5, 32'd8, 1'b0, 0);
    idle(1);
`endif
    idle(9);
    rst_n = 1'b0;
    idle(2);
    sb.delete();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_out_valid", 64'(seen), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
`ifdef ALU_MULT_EN
    send(2'b10, 6'b010010, 32'h0, 32'h0, 32'h0000_0000, 1'b0, 0);
    send(2'b10, 6'b010000, 32'h0, 32'h0, 32'h0000_0000, 1'b0, 0);
`else
    send(2'b10, 6'b010010, 32'h0, 32'h0, 32'h0000_0000, 1'b1, 0);
`endif
    send(2'b00, 6'b000000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 0);

    for (int i = 0; i < 100 && sb.size() != 0; i++) idle(1);
    idle(1);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
